// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB first, one full-adder cell.
// Operands load in parallel on an accepted start. One result bit is produced
// per non-held SHIFT edge, and the result builds up in the A shift register.
// Optional macro SERIAL_ADDSUB_OVF_EN: when defined, a registered signed-overflow
// flag is built. When undefined, the overflow output is a constant 0.
module serial_addsub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic             sub,
   input  logic             hold,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry_reg;
   logic [CW-1:0]    cnt_reg;
   logic             carry_out_reg;
   logic             s_bit;
   logic             c_bit;
   logic             last_shift;
   logic             load;
   logic             shift_en;

   // Full-adder cell on the current LSBs and the registered carry.
   always_comb begin
      s_bit      = a_reg[0] ^ b_reg[0] ^ carry_reg;
      c_bit      = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
      last_shift = (cnt_reg == CW'(WIDTH - 1));
   end

   // Next-state and handshake decode. The hold input only matters in SHIFT.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      shift_en   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (!hold) begin
               shift_en = 1'b1;
               if (last_shift) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Operand shift registers, serial carry and bit counter.
   // Subtraction is done as A + ~B + 1: B is inverted at load and the carry is preset to 1.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
      end else if (load) begin
         a_reg     <= a_in;
         b_reg     <= sub ? ~b_in : b_in;
         carry_reg <= sub;
         cnt_reg   <= '0;
      end else if (shift_en) begin
         a_reg     <= {s_bit, a_reg[WIDTH-1:1]};
         b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
         carry_reg <= c_bit;
         cnt_reg   <= cnt_reg + 1'b1;
      end
   end

   // The final carry is captured on the last shift and held until the next completion.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         carry_out_reg <= 1'b0;
      end else if (shift_en && last_shift) begin
         carry_out_reg <= c_bit;
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic overflow_reg;

   // Signed overflow is the carry into the MSB XOR the carry out of the MSB.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         overflow_reg <= 1'b0;
      end else if (shift_en && last_shift) begin
         overflow_reg <= carry_reg ^ c_bit;
      end
   end

   assign overflow = overflow_reg;
`else
   assign overflow = 1'b0;
`endif

   assign sum_out   = a_reg;
   assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub. It drives a 4-bit and an 8-bit instance with
// directed and random operations. Each result is checked against plain
// integer arithmetic.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       clear;
   logic       start4, start8;
   logic       sub, hold;
   logic [3:0] a_in4, b_in4;
   logic [7:0] a_in8, b_in8;
   logic       busy4, done4, carry4, ovf4;
   logic       busy8, done8, carry8, ovf8;
   logic [3:0] sum4;
   logic [7:0] sum8;

   logic        sel8;
   logic        busy_sel, done_sel, carry_sel, ovf_sel;
   logic [31:0] sum_sel;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(4)) dut4 (
      .clk(clk), .clear(clear), .start(start4), .sub(sub), .hold(hold),
      .a_in(a_in4), .b_in(b_in4), .busy(busy4), .done(done4),
      .sum_out(sum4), .carry_out(carry4), .overflow(ovf4)
   );

   serial_addsub #(.WIDTH(8)) dut8 (
      .clk(clk), .clear(clear), .start(start8), .sub(sub), .hold(hold),
      .a_in(a_in8), .b_in(b_in8), .busy(busy8), .done(done8),
      .sum_out(sum8), .carry_out(carry8), .overflow(ovf8)
   );

   always_comb begin
      busy_sel  = sel8 ? busy8  : busy4;
      done_sel  = sel8 ? done8  : done4;
      carry_sel = sel8 ? carry8 : carry4;
      ovf_sel   = sel8 ? ovf8   : ovf4;
      sum_sel   = sel8 ? {24'd0, sum8} : {28'd0, sum4};
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: integer arithmetic plus the sign-rule definition of overflow.
   task automatic ref_calc(input int w, input int a, input int b, input bit s,
                           output int r, output bit c, output bit v);
      longint mask = (64'd1 << w) - 1;
      longint full;
      bit sa, sb, sr;
      if (s) begin
         full = longint'(a) - longint'(b);
         c    = (a >= b);
      end else begin
         full = longint'(a) + longint'(b);
         c    = ((full >> w) & 1) != 0;
      end
      r  = int'(full & mask);
      sa = ((a >> (w - 1)) & 1) != 0;
      sb = ((b >> (w - 1)) & 1) != 0;
      sr = ((r >> (w - 1)) & 1) != 0;
`ifdef SERIAL_ADDSUB_OVF_EN
      v = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`else
      v = 1'b0;
`endif
   endtask

   // One operation. Optionally hold for hlen cycles once cnt reaches hat,
   // and optionally pulse start with new operands while busy.
   task automatic run_op(input bit w8, input int a, input int b, input bit s,
                         input int hat, input int hlen, input bit inject, input string tag);
      int w, er, cnt, res;
      bit ec, ev;
      w = w8 ? 8 : 4;
      ref_calc(w, a, b, s, er, ec, ev);
      sel8 = w8;
      sub  = s;
      if (w8) begin a_in8 = 8'(a); b_in8 = 8'(b); start8 = 1'b1; end
      else    begin a_in4 = 4'(a); b_in4 = 4'(b); start4 = 1'b1; end
      @(posedge clk); #1;
      start4 = 1'b0; start8 = 1'b0;
      cnt = 1;
      check({tag, ".busy"}, int'(busy_sel), 1);
      while (!done_sel && cnt < 60) begin
         if (hlen > 0 && cnt == hat)        hold = 1'b1;
         if (hlen > 0 && cnt == hat + hlen) hold = 1'b0;
         if (inject && cnt == 2) begin
            sub = ~s;
            if (w8) begin a_in8 = 8'hFF; start8 = 1'b1; end
            else    begin a_in4 = 4'hF;  start4 = 1'b1; end
         end
         if (inject && cnt == 3) begin start4 = 1'b0; start8 = 1'b0; end
         @(posedge clk); #1;
         cnt++;
      end
      hold = 1'b0; start4 = 1'b0; start8 = 1'b0;
      check({tag, ".done_seen"}, int'(done_sel), 1);
      check({tag, ".latency"}, cnt, w + 1 + hlen);
      check({tag, ".sum"}, int'(sum_sel), er);
      check({tag, ".carry"}, int'(carry_sel), int'(ec));
      check({tag, ".ovf"}, int'(ovf_sel), int'(ev));
      res = int'(sum_sel);
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, int'(done_sel), 0);
      check({tag, ".idle"}, int'(busy_sel), 0);
      check({tag, ".sum_held"}, int'(sum_sel), er);
      $display("op %s w=%0d a=%0d b=%0d sub=%0d hold=%0d@%0d -> sum=%0d c=%0d v=%0d lat=%0d",
               tag, w, a, b, s, hlen, hat, res, carry_sel, ovf_sel, cnt);
   endtask

   initial begin
      int w, a, b, hl;
      bit w8, s;
      bit seen;
      clear = 1'b0; start4 = 0; start8 = 0; sub = 0; hold = 0;
      a_in4 = 0; b_in4 = 0; a_in8 = 0; b_in8 = 0; sel8 = 0;
      #12;
      check("rst.busy4", int'(busy4), 0);
      check("rst.done4", int'(done4), 0);
      check("rst.sum4",  int'(sum4), 0);
      check("rst.carry4", int'(carry4), 0);
      check("rst.ovf4",  int'(ovf4), 0);
      check("rst.sum8",  int'(sum8), 0);
      @(posedge clk); #3; clear = 1'b1;
      @(posedge clk); #1;

      run_op(0, 5, 6, 0, 0, 0, 0, "add5_6");
      run_op(0, 7, 1, 0, 0, 0, 0, "add7_1");
      run_op(0, 3, 5, 1, 0, 0, 0, "sub3_5");
      run_op(0, 6, 3, 0, 3, 3, 1, "hold6_3");
      run_op(0, 9, 9, 0, 0, 0, 0, "add9_9");

      // An asynchronous reset in the middle of an operation aborts it.
      sel8 = 0; sub = 0; a_in4 = 4'd10; b_in4 = 4'd5; start4 = 1'b1;
      @(posedge clk); #1; start4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      clear = 1'b0;
      #1;
      check("abort.sum",   int'(sum4), 0);
      check("abort.busy",  int'(busy4), 0);
      check("abort.done",  int'(done4), 0);
      check("abort.carry", int'(carry4), 0);
      check("abort.ovf",   int'(ovf4), 0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done4) seen = 1;
      end
      #2; clear = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done4) seen = 1;
      end
      check("abort.no_done", int'(seen), 0);
      $display("op abort a=10 b=5 cleared after 2 shifts");
      run_op(0, 1, 2, 0, 0, 0, 0, "add1_2");

      run_op(1, 200, 100, 0, 0, 0, 0, "w8add");
      run_op(1, 100, 200, 1, 0, 0, 0, "w8sub");
      run_op(1, 128, 1, 1, 4, 2, 1, "w8subovf");

      for (int k = 0; k < 24; k++) begin
         w8 = 1'($urandom_range(0, 1));
         w  = w8 ? 8 : 4;
         a  = int'($urandom_range(0, (1 << w) - 1));
         b  = int'($urandom_range(0, (1 << w) - 1));
         s  = 1'($urandom_range(0, 1));
         hl = int'($urandom_range(0, 3));
         run_op(w8, a, b, s, int'($urandom_range(1, w)), hl,
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
